// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store initiator for the shared 32-bit word memory bus (optional MEM_LSU_MISALIGN_SPLIT_EN)
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic            we_q;
  logic            signed_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   wait_cnt;

  logic [1:0]      off_in;
  logic            misalign_in;
  logic            fault_in;
  logic [3:0]      base_mask;
  logic [31:0]     lane_data;
  logic [3:0]      lo_wmask;
  logic [31:0]     lo_wdata;
  logic [63:0]     rd_cat;
  logic [31:0]     rd_lo;
  logic [31:0]     load_ext;

  assign off_in      = req_addr[1:0];
  assign misalign_in = ((req_size == 2'b01) && off_in[0]) ||
                       ((req_size == 2'b10) && (off_in != 2'b00));

`ifdef MEM_LSU_MISALIGN_SPLIT_EN
  logic            split_q;
  logic            phase_q;
  logic [31:0]     lo_q;
  logic [31:0]     hi_wdata_q;
  logic [3:0]      hi_wmask_q;
  logic [7:0]      mask_wide;
  logic [63:0]     data_wide;

  // Misaligned half/word is carried by a second access, so only size=11 faults.
  assign fault_in  = (req_size == 2'b11);
  assign mask_wide = {4'b0000, base_mask} << off_in;
  assign data_wide = {32'h0, lane_data} << {off_in, 3'b000};
  assign lo_wmask  = mask_wide[3:0];
  assign lo_wdata  = data_wide[31:0];
  assign rd_cat    = split_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
`else
  assign fault_in  = (req_size == 2'b11) || misalign_in;
  assign lo_wmask  = base_mask << off_in;
  assign lo_wdata  = lane_data << {off_in, 3'b000};
  assign rd_cat    = {32'h0, mem_rdata};
`endif

  assign rd_lo = 32'(rd_cat >> {off_q, 3'b000});

  // Per-size lane mask and LSB-justified store data before lane shifting.
  always_comb begin
    base_mask = 4'b1111;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin base_mask = 4'b0001; lane_data = {24'h0, req_wdata[7:0]};  end
      2'b01: begin base_mask = 4'b0011; lane_data = {16'h0, req_wdata[15:0]}; end
      default: ;
    endcase
  end

  // Sign/zero extension of the lane-extracted load data.
  always_comb begin
    load_ext = rd_lo;
    case (size_q)
      2'b00: load_ext = signed_q ? {{24{rd_lo[7]}}, rd_lo[7:0]}   : {24'h0, rd_lo[7:0]};
      2'b01: load_ext = signed_q ? {{16{rd_lo[15]}}, rd_lo[15:0]} : {16'h0, rd_lo[15:0]};
      default: ;
    endcase
  end

  // Access FSM with registered bus and response outputs; mem_done only counts in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wmask   <= 4'h0;
      mem_wstrobe <= 1'b0;
      mem_rstrobe <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wait_cnt    <= '0;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      phase_q     <= 1'b0;
      lo_q        <= 32'h0;
      hi_wdata_q  <= 32'h0;
      hi_wmask_q  <= 4'h0;
`endif
    end else begin
      mem_wstrobe <= 1'b0;
      mem_rstrobe <= 1'b0;
      resp_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            off_q     <= off_in;
            if (fault_in) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state       <= S_REQ;
              mem_addr    <= {req_addr[31:2], 2'b00};
              mem_wmask   <= req_we ? lo_wmask : 4'h0;
              mem_wdata   <= req_we ? lo_wdata : 32'h0;
              mem_wstrobe <= req_we;
              mem_rstrobe <= !req_we;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
              split_q     <= misalign_in;
              phase_q     <= 1'b0;
              hi_wmask_q  <= req_we ? mask_wide[7:4] : 4'h0;
              hi_wdata_q  <= req_we ? data_wide[63:32] : 32'h0;
`endif
            end
          end
        end
        S_REQ: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (mem_done) begin
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
            if (split_q && !phase_q) begin
              phase_q     <= 1'b1;
              lo_q        <= mem_rdata;
              mem_addr    <= mem_addr + 32'd4;
              mem_wmask   <= hi_wmask_q;
              mem_wdata   <= hi_wdata_q;
              mem_wstrobe <= we_q;
              mem_rstrobe <= !we_q;
              state       <= S_REQ;
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= we_q ? 32'h0 : load_ext;
            end
`else
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'h0 : load_ext;
`endif
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed table-driven bench for mem_lsu with a word-memory responder
module tb_mem_lsu;

  localparam int M_NORMAL = 0;
  localparam int M_STUCK  = 1;
  localparam int M_STICKY = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrobe;
  logic        mem_rstrobe;
  logic [31:0] mem_rdata;
  logic        mem_done;

  int checks;
  int failures;
  int mode;

  logic [31:0] mem [0:15];
  int          nw;
  int          nr;
  logic [31:0] last_addr;
  logic [3:0]  last_wmask;
  logic [31:0] last_wdata;

  mem_lsu #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Responder: done one cycle after a strobe; STUCK never completes; STICKY keeps done high.
  initial begin
    logic        pend;
    logic        pw;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [3:0]  pm;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h80011234;
    mem[2] = 32'h11111111;
    nw = 0; nr = 0;
    last_addr = 0; last_wmask = 0; last_wdata = 0;
    mem_done = 1'b0; mem_rdata = 32'h0;
    pend = 1'b0; pw = 1'b0; pa = 0; pd = 0; pm = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        mem_done = 1'b0;
      end else begin
        if (pend) begin
          if (mode != M_STUCK) begin
            mem_rdata = mem[pa[5:2]];
            if (pw)
              for (int b = 0; b < 4; b++)
                if (pm[b]) mem[pa[5:2]][8*b +: 8] = pd[8*b +: 8];
            mem_done = 1'b1;
          end
          pend = 1'b0;
        end else if (mode != M_STICKY) begin
          mem_done = 1'b0;
        end
        if (mem_wstrobe || mem_rstrobe) begin
          pend = 1'b1;
          pw = mem_wstrobe;
          pa = mem_addr;
          pm = mem_wmask;
          pd = mem_wdata;
          last_addr = mem_addr;
          last_wmask = mem_wmask;
          last_wdata = mem_wdata;
          if (mem_wstrobe) nw++;
          if (mem_rstrobe) nr++;
        end
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge; returns in the response cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic err, output logic [31:0] rdata);
    int n;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_bound actual=not_ready required=ready");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL resp_bound actual=no_resp required=resp_valid");
    end
    err = resp_err;
    rdata = resp_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    int          nw;
    int          nr;
    logic [31:0] maddr;
    logic [3:0]  wmask;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs [0:17];

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          w0, r0, n;

    vecs[0]  = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,        1'b0, 3, 32'hFFFF8001, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h7, 32'h0,        1'b0, 3, 32'h00000080, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h7, 32'h0,        1'b0, 3, 32'hFFFFFF80, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h4, 32'h0,        1'b0, 3, 32'h00001234, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        1'b0, 3, 32'h80011234, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h5, 32'h123456AB, 1'b0, 3, 32'h0,        1, 0, 32'h4, 4'b0010, 32'h0000AB00};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        1'b0, 3, 32'h8001AB34, 0, 1, 32'h4, 4'h0, 32'h0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'hA, 32'hFFFF5678, 1'b0, 3, 32'h0,        1, 0, 32'h8, 4'b1100, 32'h56780000};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'hA, 32'h0,        1'b0, 3, 32'h00005678, 0, 1, 32'h8, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        1'b0, 3, 32'h56781111, 0, 1, 32'h8, 4'h0, 32'h0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'hC, 32'hDEADBEEF, 1'b0, 3, 32'h0,        1, 0, 32'hC, 4'b1111, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 32'hC, 32'h0,        1'b0, 3, 32'hFFFFFFEF, 0, 1, 32'hC, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 2'd1, 1'b1, 32'hE, 32'h0,        1'b0, 3, 32'hFFFFDEAD, 0, 1, 32'hC, 4'h0, 32'h0};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 32'hE, 32'h0,        1'b0, 3, 32'h0000DEAD, 0, 1, 32'hC, 4'h0, 32'h0};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0,        1'b1, 1, 32'h0,        0, 0, 32'h0, 4'h0, 32'h0};
    vecs[15] = '{1'b1, 2'd3, 1'b0, 32'h4, 32'hFFFFFFFF, 1'b1, 1, 32'h0,        0, 0, 32'h0, 4'h0, 32'h0};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 32'hF, 32'h000000C7, 1'b0, 3, 32'h0,        1, 0, 32'hC, 4'b1000, 32'hC7000000};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'hF, 32'h0,        1'b0, 3, 32'h000000C7, 0, 1, 32'hC, 4'h0, 32'h0};

    checks = 0; failures = 0; mode = M_NORMAL;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_strobes", {30'h0, mem_wstrobe, mem_rstrobe}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 18; i++) begin
      w0 = nw; r0 = nr;
      issue(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, lat, err, rd);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_nw", i), 32'(nw - w0), 32'(vecs[i].nw));
      chk($sformatf("v%0d_nr", i), 32'(nr - r0), 32'(vecs[i].nr));
      if (vecs[i].nw + vecs[i].nr > 0) begin
        chk($sformatf("v%0d_maddr", i), last_addr, vecs[i].maddr);
        chk($sformatf("v%0d_wmask", i), {28'h0, last_wmask}, {28'h0, vecs[i].wmask});
        if (vecs[i].we) chk($sformatf("v%0d_mwdata", i), last_wdata, vecs[i].mwdata);
      end
    end

    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h44332211, lat, err, rd);
    chk("restore_err", {31'h0, err}, 32'h0);

    w0 = nw; r0 = nr;
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, lat, err, rd);
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
    chk("split_lw_err", {31'h0, err}, 32'h0);
    chk("split_lw_rdata", rd, 32'h2211DDCC);
    chk("split_lw_nr", 32'(nr - r0), 32'd2);
    chk("split_lw_lat", 32'(lat), 32'd5);
    chk("split_lw_addr1", last_addr, 32'h4);
`else
    chk("mis_lw_err", {31'h0, err}, 32'h1);
    chk("mis_lw_lat", 32'(lat), 32'd1);
    chk("mis_lw_rdata", rd, 32'h0);
    chk("mis_lw_strobes", 32'(nr - r0 + nw - w0), 32'd0);
    w0 = nw; r0 = nr;
    issue(1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, lat, err, rd);
    chk("mis_sh_err", {31'h0, err}, 32'h1);
    chk("mis_sh_strobes", 32'(nr - r0 + nw - w0), 32'd0);
`endif

    mode = M_STUCK;
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, err, rd);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_lat", 32'(lat), 32'd17);
    chk("tmo_rdata", rd, 32'h0);
    mode = M_NORMAL;
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, err, rd);
    chk("after_tmo_err", {31'h0, err}, 32'h0);
    chk("after_tmo_rdata", rd, 32'h44332211);

    mode = M_STICKY;
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, lat, err, rd);
    chk("b2b_sw_err", {31'h0, err}, 32'h0);
    chk("resp_ready_low", {31'h0, req_ready}, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, err, rd);
    chk("b2b_lw_rdata", rd, 32'hCAFEF00D);
    chk("b2b_lw_lat", 32'(lat), 32'd3);
    mode = M_NORMAL;
    @(posedge clk); #1;

    mode = M_STUCK;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("wait_addr_held", mem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {30'h0, mem_wstrobe, mem_rstrobe}, 32'h0);
    chk("midrst_addr", mem_addr, 32'h0);
    chk("midrst_ready", {31'h0, req_ready}, 32'h0);
    chk("midrst_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = M_NORMAL;
    @(posedge clk); #1;
    chk("midrst_release_ready", {31'h0, req_ready}, 32'h1);
    n = 0;
    repeat (6) begin
      if (resp_valid) n++;
      @(posedge clk); #1;
    end
    chk("midrst_no_resp", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
